// File: rtl/uart_boot_loader.sv
// Framed UART program loader: SYNC, 16-bit word count, payload packed into memory words.
// Define BOOT_CHECKSUM_EN to append and verify a mod-256 payload checksum byte.
module uart_boot_loader #(
    parameter int                WORD_BYTES     = 4,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                MAX_WORDS      = 4096,
    parameter int                TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]        SYNC_BYTE      = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic                    disarm,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    loading,
    output logic                    mem_we,
    input  logic                    mem_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    done,
    output logic [2:0]              err_code
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);
    localparam int BC_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int DW    = 8 * WORD_BYTES;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_LENGTH  = 3'd2;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [2:0] ERR_CSUM    = 3'd3;
`endif
    localparam logic [2:0] ERR_OVERRUN = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_LEN0  = 3'd2,
        ST_LEN1  = 3'd3,
        ST_DATA  = 3'd4,
        ST_WRITE = 3'd5,
`ifdef BOOT_CHECKSUM_EN
        ST_CSUM  = 3'd6,
`endif
        ST_DONE  = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [2:0]        err_q, err_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              counting;
    logic              last_byte;
    logic              last_word;
    logic [15:0]       rx_len;
    state_e            after_payload;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            wdata_q    <= '0;
            err_q      <= ERR_NONE;
            tmo_q      <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d     = csum_q;
        after_payload = ST_CSUM;
`else
        after_payload = ST_DONE;
`endif

        counting = (state_q == ST_LEN0) || (state_q == ST_LEN1) || (state_q == ST_DATA)
`ifdef BOOT_CHECKSUM_EN
                   || (state_q == ST_CSUM)
`endif
                   ;
        tmo_d     = (counting && !rx_valid) ? tmo_q + TO_W'(1) : '0;
        last_byte = (byte_cnt_q == BC_W'(WORD_BYTES - 1));
        last_word = ((32'(word_idx_q) + 32'd1) == 32'(len_q));
        rx_len    = {rx_data, len_q[7:0]};

        case (state_q)
            ST_SYNC: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d    = ST_LEN0;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
`ifdef BOOT_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            ST_LEN0: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    state_d    = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (rx_valid) begin
                    len_d = rx_len;
                    if (rx_len == 16'd0) begin
                        state_d = after_payload;
                    end else if (32'(rx_len) > 32'(MAX_WORDS)) begin
                        state_d = ST_SYNC;
                        err_d   = ERR_LENGTH;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
`ifdef BOOT_CHECKSUM_EN
                    csum_d = csum_q + rx_data;
`endif
                    if (last_byte) begin
                        byte_cnt_d = '0;
                        state_d    = ST_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    word_idx_d = word_idx_q + IDX_W'(1);
                    state_d    = last_word ? after_payload : ST_DATA;
                    // A byte landing on the acceptance cycle belongs to whatever follows the write.
                    if (rx_valid && !last_word) begin
                        wdata_d[7:0] = rx_data;
`ifdef BOOT_CHECKSUM_EN
                        csum_d = csum_q + rx_data;
`endif
                        if (WORD_BYTES == 1) state_d = ST_WRITE;
                        else                 byte_cnt_d = BC_W'(1);
                    end
`ifdef BOOT_CHECKSUM_EN
                    else if (rx_valid) begin
                        state_d = (rx_data == csum_q) ? ST_DONE : ST_SYNC;
                        if (rx_data != csum_q) err_d = ERR_CSUM;
                    end
`endif
                end else if (rx_valid) begin
                    state_d = ST_SYNC;
                    err_d   = ERR_OVERRUN;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SYNC;
                        err_d   = ERR_CSUM;
                    end
                end
            end
`endif
            default: ;
        endcase

        if (counting && !rx_valid && tmo_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_SYNC;
            err_d   = ERR_TIMEOUT;
            tmo_d   = '0;
        end

        if (disarm) begin
            state_d    = ST_IDLE;
            byte_cnt_d = '0;
            tmo_d      = '0;
        end else if (arm) begin
            state_d    = ST_SYNC;
            word_idx_d = '0;
            byte_cnt_d = '0;
            err_d      = ERR_NONE;
            tmo_d      = '0;
        end
    end

    always_comb begin
        loading   = (state_q != ST_IDLE);
        mem_we    = (state_q == ST_WRITE);
        done      = (state_q == ST_DONE);
        mem_addr  = BASE_ADDR + ADDR_W'(word_idx_q) * ADDR_W'(WORD_BYTES);
        mem_wdata = wdata_q;
        err_code  = err_q;
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboarded bench for uart_boot_loader: directed frames with hand-computed writes and status.
module tb_uart_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          TMO  = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        disarm = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        loading;
    logic        mem_we;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        done;
    logic [2:0]  err_code;

    logic [63:0] exp_q[$];
    logic [63:0] exp_w;
    int          tests = 0;
    int          fails = 0;

    uart_boot_loader #(
        .WORD_BYTES(4), .ADDR_W(32), .BASE_ADDR(BASE),
        .MAX_WORDS(4096), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .disarm(disarm),
        .rx_valid(rx_valid), .rx_data(rx_data), .loading(loading),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .done(done), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Every accepted write is matched in order against the expected-write queue.
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", mem_addr, mem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                checkOutput("write_addr", {32'd0, mem_addr}, {32'd0, exp_w[63:32]});
                checkOutput("write_data", {32'd0, mem_wdata}, {32'd0, exp_w[31:0]});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(b);
        idle(2);
    endtask

    task automatic pulse(input logic a, input logic d);
        @(posedge clk); #1;
        arm    = a;
        disarm = d;
        @(posedge clk); #1;
        arm    = 1'b0;
        disarm = 1'b0;
    endtask

    task automatic expectWrite(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_loading"}, {63'd0, loading}, 64'd0);
        checkOutput({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
        checkOutput({tag, "_mem_addr"}, {32'd0, mem_addr}, {32'd0, BASE});
        checkOutput({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
        checkOutput({tag, "_done"}, {63'd0, done}, 64'd0);
        checkOutput({tag, "_err"}, {61'd0, err_code}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values
        idle(3);
        checkReset("reset");
        rst = 1'b0;
        idle(2);

        // Two-word frame, memory always ready
        pulse(1'b1, 1'b0);
        checkOutput("armed_loading", {63'd0, loading}, 64'd1);
        expectWrite(BASE, 32'h4433_2211);
        expectWrite(BASE + 32'd4, 32'h8877_6655);
        sendByte(8'hA5); sendByte(8'h02); sendByte(8'h00);
        sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
        sendByte(8'h55); sendByte(8'h66); sendByte(8'h77); sendByte(8'h88);
`ifdef BOOT_CHECKSUM_EN
        sendByte(8'h64);
`endif
        checkOutput("frame_done", {63'd0, done}, 64'd1);
        checkOutput("frame_err", {61'd0, err_code}, 64'd0);
        checkOutput("frame_loading", {63'd0, loading}, 64'd1);

`ifdef BOOT_CHECKSUM_EN
        // Same frame with a wrong checksum
        pulse(1'b1, 1'b0);
        expectWrite(BASE, 32'h4433_2211);
        expectWrite(BASE + 32'd4, 32'h8877_6655);
        sendByte(8'hA5); sendByte(8'h02); sendByte(8'h00);
        sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
        sendByte(8'h55); sendByte(8'h66); sendByte(8'h77); sendByte(8'h88);
        sendByte(8'h65);
        checkOutput("csum_err", {61'd0, err_code}, 64'd3);
        checkOutput("csum_done", {63'd0, done}, 64'd0);
        checkOutput("csum_loading", {63'd0, loading}, 64'd1);
`endif

        // Length 0x1001 exceeds MAX_WORDS; no write may follow
        pulse(1'b1, 1'b0);
        sendByte(8'hA5); sendByte(8'h01); sendByte(8'h10);
        checkOutput("len_err", {61'd0, err_code}, 64'd2);
        checkOutput("len_mem_we", {63'd0, mem_we}, 64'd0);

        // A valid frame after the error still loads, error stays latched
        expectWrite(BASE, 32'hEFBE_ADDE);
        sendByte(8'hA5); sendByte(8'h01); sendByte(8'h00);
        sendByte(8'hDE); sendByte(8'hAD); sendByte(8'hBE); sendByte(8'hEF);
`ifdef BOOT_CHECKSUM_EN
        sendByte(8'h38);
`endif
        checkOutput("sticky_done", {63'd0, done}, 64'd1);
        checkOutput("sticky_err", {61'd0, err_code}, 64'd2);

        // arm and disarm together: disarm wins
        pulse(1'b1, 1'b1);
        checkOutput("armdis_loading", {63'd0, loading}, 64'd0);
        checkOutput("armdis_done", {63'd0, done}, 64'd0);

        // Overrun: memory stalls, next byte arrives during the pending write
        pulse(1'b1, 1'b0);
        checkOutput("rearm_err", {61'd0, err_code}, 64'd0);
        sendByte(8'hA5); sendByte(8'h01); sendByte(8'h00);
        mem_ready = 1'b0;
        sendByte(8'hAA); sendByte(8'hBB); sendByte(8'hCC);
        applyStimulus(8'hDD);
        checkOutput("stall_mem_we", {63'd0, mem_we}, 64'd1);
        checkOutput("stall_addr", {32'd0, mem_addr}, {32'd0, BASE});
        checkOutput("stall_wdata", {32'd0, mem_wdata}, 64'hDDCC_BBAA);
        idle(9);
        applyStimulus(8'h01);
        checkOutput("ovr_mem_we", {63'd0, mem_we}, 64'd0);
        checkOutput("ovr_err", {61'd0, err_code}, 64'd4);
        checkOutput("ovr_done", {63'd0, done}, 64'd0);
        idle(10);
        mem_ready = 1'b1;
        idle(3);

        // Timeout after two payload bytes, then recovery from SYNC
        pulse(1'b1, 1'b0);
        sendByte(8'hA5); sendByte(8'h02); sendByte(8'h00);
        sendByte(8'h11); sendByte(8'h22);
        idle(TMO + 10);
        checkOutput("tmo_err", {61'd0, err_code}, 64'd1);
        checkOutput("tmo_loading", {63'd0, loading}, 64'd1);
        checkOutput("tmo_mem_we", {63'd0, mem_we}, 64'd0);
        expectWrite(BASE, 32'h0403_0201);
        sendByte(8'hA5); sendByte(8'h01); sendByte(8'h00);
        sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
`ifdef BOOT_CHECKSUM_EN
        sendByte(8'h0A);
`endif
        checkOutput("tmo_recover_done", {63'd0, done}, 64'd1);
        checkOutput("tmo_recover_err", {61'd0, err_code}, 64'd1);

        // disarm in the middle of a word
        pulse(1'b1, 1'b0);
        sendByte(8'hA5); sendByte(8'h01); sendByte(8'h00);
        sendByte(8'h11); sendByte(8'h22);
        pulse(1'b0, 1'b1);
        checkOutput("disarm_loading", {63'd0, loading}, 64'd0);
        checkOutput("disarm_mem_we", {63'd0, mem_we}, 64'd0);
        checkOutput("disarm_done", {63'd0, done}, 64'd0);

        // rst while a write is pending
        pulse(1'b1, 1'b0);
        sendByte(8'hA5); sendByte(8'h01); sendByte(8'h00);
        mem_ready = 1'b0;
        sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
        applyStimulus(8'h44);
        checkOutput("pre_rst_mem_we", {63'd0, mem_we}, 64'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checkReset("midrst");
        mem_ready = 1'b1;
        idle(5);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL pending_writes: got %0d outstanding, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
